// File: rtl/seq_div_restoring.sv
// Iterative unsigned restoring divider: one quotient bit per clock, valid/ready
// on both the operand and the result side, with a divide-by-zero flag.
module seq_div_restoring #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  // state | meaning
  // IDLE  | waiting for an operand pair, in_ready=1
  // CALC  | iterating, one quotient bit per cycle for W cycles
  // DONE  | result held on the outputs until out_ready, out_valid=1
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = $clog2(W);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   dvsr;
  logic [W-1:0]   q;
  // The top bit of the partial remainder is always 0 between iterations,
  // so only W bits are stored; the shifted value is rebuilt W+1 wide.
  logic [W-1:0]   rem;
  logic [W:0]     rem_sh;
  logic [W:0]     diff;
  logic           dbz;
  logic           accept;
  logic           last;

  assign accept = in_valid && (state == IDLE);
  assign last   = (cnt == CW'(W - 1));
  assign rem_sh = {rem, q[W-1]};
  assign diff   = rem_sh - {1'b0, dvsr};

  assign quotient    = q;
  assign remainder   = rem;
  assign div_by_zero = dbz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dvsr <= '0;
      q    <= '0;
      rem  <= '0;
      dbz  <= 1'b0;
    end else if (accept) begin
      dvsr <= divisor;
      cnt  <= '0;
      if (divisor == '0) begin
        q   <= '1;
        rem <= dividend;
        dbz <= 1'b1;
      end else begin
        q   <= dividend;
        rem <= '0;
        dbz <= 1'b0;
      end
    end else if (state == CALC) begin
      cnt <= cnt + CW'(1);
      if (!diff[W]) begin
        rem <= diff[W-1:0];
        q   <= {q[W-2:0], 1'b1};
      end else begin
        rem <= rem_sh[W-1:0];
        q   <= {q[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_seq_div_restoring.sv
// Directed and randomized checks for seq_div_restoring at W=8: results,
// latency, back-pressure stability, ignored operands and mid-operation reset.
module tb_seq_div_restoring;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_chk  = 0;
  int n_pass = 0;

  seq_div_restoring #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Issue one operation, check latency and result, then drain it.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                        input int gap, input int hold);
    int lat;
    int waits;
    repeat (gap) @(posedge clk);
    @(negedge clk);
    waits = 0;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    chk({tag, " in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    dividend = $urandom_range(255);
    divisor  = $urandom_range(255);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, " latency"}, lat, (b == 0) ? 1 : W + 1);
    chk({tag, " in_ready low in DONE"}, in_ready, 0);
    repeat (hold) begin
      @(negedge clk);
      chk({tag, " held q"}, quotient, eq);
    end
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, div_by_zero, ez);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " out_valid dropped"}, out_valid, 0);
    chk({tag, " in_ready back"}, in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] ra, rb, rq, rr;

    #12;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("200/7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 0, 0);
    run_op("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 0, 0);
    run_op("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 0, 0);
    run_op("0/5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 0, 0);
    run_op("5/9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 0, 0);
    run_op("13/0", 8'd13, 8'd0, 8'hFF, 8'd13, 1'b1, 0, 0);
    run_op("14/3", 8'd14, 8'd3, 8'd4, 8'd2, 1'b0, 0, 0);

    // Back-pressure with in_valid and operands wiggling throughout.
    @(negedge clk);
    in_valid = 1'b1; dividend = 8'd100; divisor = 8'd9;
    @(posedge clk);
    for (int i = 0; i < W; i++) begin
      #1 in_valid = i[0]; dividend = 8'd50 + 8'(i); divisor = 8'(i);
      @(negedge clk);
      chk("bp in_ready in CALC", in_ready, 0);
      @(posedge clk);
    end
    #1 in_valid = 1'b1; dividend = 8'd3; divisor = 8'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp out_valid held", out_valid, 1);
      chk("bp q held", quotient, 11);
      chk("bp r held", remainder, 1);
      chk("bp dbz held", div_by_zero, 0);
      dividend = 8'(i * 37);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp single transfer", out_valid, 0);
    chk("bp idle after", in_ready, 1);
    @(negedge clk);
    chk("bp no stray accept", in_ready, 1);

    // Reset in the middle of a divide.
    in_valid = 1'b1; dividend = 8'd77; divisor = 8'd5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst quotient", quotient, 0);
    chk("rst remainder", remainder, 0);
    chk("rst dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("77/5 after rst", 8'd77, 8'd5, 8'd15, 8'd2, 1'b0, 0, 0);

    // Random pairs against a reference model, with random gaps and stalls.
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom_range(255));
      rb = (i % 17 == 0) ? 8'd0 : 8'($urandom_range(255));
      if (rb == 0) begin
        rq = 8'hFF;
        rr = ra;
      end else begin
        rq = ra / rb;
        rr = ra % rb;
      end
      run_op("rand", ra, rb, rq, rr, rb == 0, $urandom_range(2), $urandom_range(3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
